// File: rtl/vram_arb_pkg.sv
// Shared constants and types for the VRAM tile arbiter.
package vram_arb_pkg;

    // Pixel slot (hpos[2:0]) assignments within each 8-pixel tile window
    localparam logic [2:0] SLOT_NAME  = 3'd0;
    localparam logic [2:0] SLOT_PAT   = 3'd1;
    localparam logic [2:0] SLOT_LATCH = 3'd2;
    localparam logic [2:0] SLOT_LOAD  = 3'd7;

    // Owner of the RAM read issued in the previous cycle
    typedef enum logic [1:0] {
        TAG_NONE,
        TAG_NAME,
        TAG_PAT,
        TAG_CPU
    } tag_e;

    // CPU access FSM states
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACK  = 1'b1;

endpackage

// File: rtl/tile_shifter.sv
// Pattern byte latch plus 8-bit left shifter producing the tile pixel stream.
module tile_shifter (
    input  logic       clk_i,
    input  logic       reset_ni,
    input  logic       latch_i,
    input  logic       load_i,
    input  logic       shift_en_i,
    input  logic       display_on_i,
    input  logic [7:0] data_i,
    output logic       pixel_o
);

    logic [7:0] next_bits_q;
    logic [7:0] shifter_q;

    // Capture the fetched pattern byte for the upcoming column
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            next_bits_q <= '0;
        end else if (latch_i) begin
            next_bits_q <= data_i;
        end
    end

    // Load at the tile boundary, otherwise shift out MSB-first while displaying
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            shifter_q <= '0;
        end else if (load_i) begin
            shifter_q <= next_bits_q;
        end else if (shift_en_i) begin
            shifter_q <= {shifter_q[6:0], 1'b0};
        end
    end

    assign pixel_o = shifter_q[7] & display_on_i;

endmodule

// File: rtl/vram_tile_arbiter.sv
// Shares one single-port VRAM between tile fetch (fixed slots) and a CPU port.
module vram_tile_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned       ADDR_W       = 11,
    parameter logic [ADDR_W-1:0] PAT_BASE     = 11'h400,
    parameter int unsigned       PREFETCH_COL = 37
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic [8:0]        hpos_i,
    input  logic [8:0]        vpos_i,
    input  logic              display_on_i,
    input  logic              cpu_req_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [7:0]        cpu_wdata_i,
    output logic              cpu_ack_o,
    output logic [7:0]        cpu_rdata_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [7:0]        ram_wdata_o,
    input  logic [7:0]        ram_rdata_i,
    output logic              pixel_o
);

    localparam logic [5:0] PF_COL = PREFETCH_COL[5:0];

    logic [2:0]        slot;
    logic              active_win;
    logic [7:0]        row;
    logic [4:0]        col;
    logic [7:0]        name_byte;
    logic [ADDR_W-1:0] name_addr;
    logic [ADDR_W-1:0] pat_addr;
    logic              cpu_issue;
    logic              cpu_rd_ret;
    logic              state_q, state_d;
    tag_e              tag_q, tag_d;
    logic [7:0]        name_q;
    logic [7:0]        rdata_q;
    logic              rd_q;
    logic              unused_bits;

    assign slot       = hpos_i[2:0];
    assign active_win = display_on_i | (hpos_i[8:3] == PF_COL);

    // Fetch coordinates: current line in display, column 0 of next line in prefetch.
    // Only row[7:0] is ever used, so the 9-bit wrap of vpos+1 reduces to 8 bits.
    always_comb begin
        row = vpos_i[7:0] + 8'd1;
        col = 5'd0;
        if (display_on_i) begin
            row = vpos_i[7:0];
            col = hpos_i[7:3] + 5'd1;
        end
    end

    // Name byte comes straight off the RAM in slot 1; fall back to the latch otherwise
    assign name_byte = (tag_q == TAG_NAME) ? ram_rdata_i : name_q;
    assign name_addr = ADDR_W'({row[7:3], col});
    assign pat_addr  = PAT_BASE + ADDR_W'({name_byte[6:0], row[2:0]});

    assign cpu_rd_ret  = (tag_q == TAG_CPU) & rd_q;
    assign unused_bits = ^{vpos_i[8], name_byte[7]};

    // RAM port mux: video slots first, CPU issue only in free cycles while IDLE
    always_comb begin
        tag_d       = TAG_NONE;
        ram_addr_o  = '0;
        ram_we_o    = 1'b0;
        ram_wdata_o = '0;
        cpu_issue   = 1'b0;
        if (!reset_ni) begin
            tag_d = TAG_NONE;
        end else if (active_win && slot == SLOT_NAME) begin
            ram_addr_o = name_addr;
            tag_d      = TAG_NAME;
        end else if (active_win && slot == SLOT_PAT) begin
            ram_addr_o = pat_addr;
            tag_d      = TAG_PAT;
        end else if (state_q == ST_IDLE && cpu_req_i) begin
            cpu_issue   = 1'b1;
            ram_addr_o  = cpu_addr_i;
            ram_we_o    = cpu_we_i;
            ram_wdata_o = cpu_wdata_i;
            tag_d       = TAG_CPU;
        end
    end

    // CPU FSM next state: ACK always lasts exactly one cycle
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: state_d = cpu_issue ? ST_ACK : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State, read-owner tag and data capture registers
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            tag_q   <= TAG_NONE;
            name_q  <= '0;
            rdata_q <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            rd_q    <= cpu_issue & ~cpu_we_i;
            if (tag_q == TAG_NAME) begin
                name_q <= ram_rdata_i;
            end
            if (cpu_rd_ret) begin
                rdata_q <= ram_rdata_i;
            end
        end
    end

    assign cpu_ack_o   = (state_q == ST_ACK);
    // Read data is live in the ack cycle, then held by the capture register
    assign cpu_rdata_o = cpu_rd_ret ? ram_rdata_i : rdata_q;

    tile_shifter u_tile_shifter (
        .clk_i        (clk_i),
        .reset_ni     (reset_ni),
        .latch_i      (active_win && slot == SLOT_LATCH && tag_q == TAG_PAT),
        .load_i       (active_win && slot == SLOT_LOAD),
        .shift_en_i   (display_on_i && slot != SLOT_LOAD),
        .display_on_i (display_on_i),
        .data_i       (ram_rdata_i),
        .pixel_o      (pixel_o)
    );

endmodule

// File: tb/tb_vram_tile_arbiter.sv
// Directed bench for vram_tile_arbiter: the bench plays the RAM by hand.
module tb_vram_tile_arbiter;

    logic        clk;
    logic        reset_n;
    logic [8:0]  hpos;
    logic [8:0]  vpos;
    logic        display_on;
    logic        cpu_req;
    logic        cpu_we;
    logic [10:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [10:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        pixel;

    int checks = 0;
    int errors = 0;

    vram_tile_arbiter dut (
        .clk_i        (clk),
        .reset_ni     (reset_n),
        .hpos_i       (hpos),
        .vpos_i       (vpos),
        .display_on_i (display_on),
        .cpu_req_i    (cpu_req),
        .cpu_we_i     (cpu_we),
        .cpu_addr_i   (cpu_addr),
        .cpu_wdata_i  (cpu_wdata),
        .cpu_ack_o    (cpu_ack),
        .cpu_rdata_o  (cpu_rdata),
        .ram_addr_o   (ram_addr),
        .ram_we_o     (ram_we),
        .ram_wdata_o  (ram_wdata),
        .ram_rdata_i  (ram_rdata),
        .pixel_o      (pixel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        pat = 8'hA5;

        // Reset values, with video inputs active to show the outputs are forced
        reset_n = 1'b0; display_on = 1'b1; vpos = 9'd0; hpos = 9'd0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; ram_rdata = '0;
        #3;
        chk("rst_ack",   16'(cpu_ack),   16'h0);
        chk("rst_rdata", 16'(cpu_rdata), 16'h0);
        chk("rst_we",    16'(ram_we),    16'h0);
        chk("rst_addr",  16'(ram_addr),  16'h0);
        chk("rst_wdata", 16'(ram_wdata), 16'h0);
        chk("rst_pixel", 16'(pixel),     16'h0);

        // Name/pattern fetch for column 1, row 0
        tick(); reset_n = 1'b1; hpos = 9'd0; #1;
        chk("name_addr_s0", 16'(ram_addr), 16'h001);
        chk("name_we_s0",   16'(ram_we),   16'h0);
        tick(); hpos = 9'd1; ram_rdata = 8'h05; #1;
        chk("pat_addr_s1", 16'(ram_addr), 16'h428);
        chk("pat_we_s1",   16'(ram_we),   16'h0);
        tick(); hpos = 9'd2; ram_rdata = 8'hA5; #1;
        chk("s2_we", 16'(ram_we), 16'h0);
        for (int h = 3; h < 8; h++) begin
            tick(); hpos = 9'(h); ram_rdata = 8'h00; #1;
        end
        // Column 1 pixels at hpos 8..15
        for (int i = 0; i < 8; i++) begin
            tick(); hpos = 9'(8 + i); #1;
            chk($sformatf("pixel_h%0d", 8 + i), 16'(pixel), 16'(pat[7 - i]));
        end

        // CPU write requested in slot 0: blocked until slot 2, ack in slot 3
        tick(); hpos = 9'd16; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 11'h123; cpu_wdata = 8'h5A; #1;
        chk("wr_blk_s0_we",   16'(ram_we),   16'h0);
        chk("wr_blk_s0_addr", 16'(ram_addr), 16'h003);
        tick(); hpos = 9'd17; ram_rdata = 8'h00; #1;
        chk("wr_blk_s1_we",   16'(ram_we),   16'h0);
        chk("wr_blk_s1_addr", 16'(ram_addr), 16'h400);
        tick(); hpos = 9'd18; #1;
        chk("wr_issue_we",    16'(ram_we),    16'h1);
        chk("wr_issue_addr",  16'(ram_addr),  16'h123);
        chk("wr_issue_wdata", 16'(ram_wdata), 16'h5A);
        chk("wr_issue_ack",   16'(cpu_ack),   16'h0);
        tick(); hpos = 9'd19; #1;
        chk("wr_ack",       16'(cpu_ack),   16'h1);
        chk("wr_ack_we",    16'(ram_we),    16'h0);
        chk("wr_ack_rdata", 16'(cpu_rdata), 16'h0);
        cpu_req = 1'b0;
        tick(); hpos = 9'd20; #1;
        chk("wr_ack_pulse", 16'(cpu_ack), 16'h0);
        tick(); hpos = 9'd21;
        tick(); hpos = 9'd22;

        // CPU read issued at slot 7, data returns during the next slot-0 fetch
        tick(); hpos = 9'd23; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h200; #1;
        chk("rd_issue_addr", 16'(ram_addr), 16'h200);
        chk("rd_issue_we",   16'(ram_we),   16'h0);
        tick(); hpos = 9'd24; ram_rdata = 8'h3C; #1;
        chk("rd_ack",        16'(cpu_ack),   16'h1);
        chk("rd_ack_rdata",  16'(cpu_rdata), 16'h3C);
        chk("rd_video_name", 16'(ram_addr),  16'h004);
        tick(); hpos = 9'd25; cpu_req = 1'b0; ram_rdata = 8'h02; #1;
        chk("rd_ack_pulse",  16'(cpu_ack),   16'h0);
        chk("rd_rdata_hold", 16'(cpu_rdata), 16'h3C);
        chk("rd_video_pat",  16'(ram_addr),  16'h410);

        // Blanking, request held: one access every second cycle
        tick(); display_on = 1'b0; hpos = 9'd100; cpu_req = 1'b1; cpu_we = 1'b0;
        cpu_addr = 11'h055; ram_rdata = 8'h00; #1;
        chk("blank_ack0",  16'(cpu_ack),  16'h0);
        chk("blank_addr0", 16'(ram_addr), 16'h055);
        chk("blank_pixel", 16'(pixel),    16'h0);
        tick(); hpos = 9'd101; #1;
        chk("blank_ack1",   16'(cpu_ack), 16'h1);
        chk("blank_we1",    16'(ram_we),  16'h0);
        chk("blank_pixel1", 16'(pixel),   16'h0);
        tick(); hpos = 9'd102; #1;
        chk("blank_ack2",  16'(cpu_ack),  16'h0);
        chk("blank_addr2", 16'(ram_addr), 16'h055);
        tick(); hpos = 9'd103; #1;
        chk("blank_ack3", 16'(cpu_ack), 16'h1);
        // Prefetch window: row vpos+1 = 16, column 0
        tick(); hpos = 9'd296; vpos = 9'd15; cpu_req = 1'b0; #1;
        chk("prefetch_addr", 16'(ram_addr), 16'h040);
        chk("prefetch_ack",  16'(cpu_ack),  16'h0);

        // Reset asserted during the ACK cycle
        tick(); hpos = 9'd120; vpos = 9'd0; cpu_req = 1'b1; cpu_we = 1'b1;
        cpu_addr = 11'h0AA; cpu_wdata = 8'h11; #1;
        chk("mid_issue_we", 16'(ram_we), 16'h1);
        tick(); hpos = 9'd121; #1;
        chk("mid_ack", 16'(cpu_ack), 16'h1);
        #2; reset_n = 1'b0; #1;
        chk("mid_rst_ack", 16'(cpu_ack), 16'h0);
        chk("mid_rst_we",  16'(ram_we),  16'h0);
        cpu_req = 1'b0;
        tick(); reset_n = 1'b1; display_on = 1'b1; hpos = 9'd0; #1;
        chk("post_rst_ack",   16'(cpu_ack),  16'h0);
        chk("post_rst_pixel", 16'(pixel),    16'h0);
        chk("post_rst_name",  16'(ram_addr), 16'h001);
        tick(); hpos = 9'd1; ram_rdata = 8'h00; #1;
        chk("post_rst_ack1",   16'(cpu_ack), 16'h0);
        chk("post_rst_pixel1", 16'(pixel),   16'h0);
        // FSM back in IDLE: a fresh request issues in the first free slot
        tick(); hpos = 9'd2; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h077; #1;
        chk("post_rst_issue", 16'(ram_addr), 16'h077);
        tick(); hpos = 9'd3; #1;
        chk("post_rst_ack2", 16'(cpu_ack), 16'h1);
        cpu_req = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_tile_arbiter.md
Name: vram_tile_arbiter

Overview:
- Shares one synchronous single-port video RAM between the tile-display fetch path and a CPU requester.
- Fetch timing is driven by the hvsync generator's hpos/vpos/display_on.
- During active video, fixed time slots in each 8-pixel tile window go to name-table and pattern fetches; all other cycles go to the CPU.
- Fetched pattern bytes feed an 8-bit pixel shifter, producing a 1-bit pixel stream aligned to hpos.

Parameters:
- ADDR_W, 11, RAM address width.
- PAT_BASE, 11'h400, base address of pattern table; name table is at 0.
- PREFETCH_COL, 37, value of hpos[8:3] during which column 0 of the next line is fetched.

Ports:
- clk  in  1  pixel clock, single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- hpos  in  9  horizontal counter from hvsync generator.
- vpos  in  9  vertical counter from hvsync generator.
- display_on  in  1  active-area flag from hvsync generator.
- cpu_req  in  1  CPU access request; held high until cpu_ack.
- cpu_we  in  1  1=write, 0=read; stable while cpu_req is high.
- cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high.
- cpu_wdata  in  8  CPU write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  8  read data, valid in the cpu_ack cycle; holds its value otherwise.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  8  RAM write data.
- ram_rdata  in  8  RAM read data; 1-cycle latency from ram_addr.
- pixel  out  1  tile pixel; 0 outside display_on.

Behaviour:
- Reset (async, reset_n=0) values:
  - cpu_ack=0, cpu_rdata=0, ram_we=0, ram_addr=0, ram_wdata=0.
  - shifter=0, next_bits=0, name latch=0, FSM=IDLE, read-owner tag=NONE.
- slot = hpos[2:0]. A fetch window is active when display_on=1 or hpos[8:3]==PREFETCH_COL.
- Fetch coordinates:
  - fetch row: vpos in display; vpos+1 (9-bit wrap) in the prefetch window.
  - fetch column: (hpos[7:3]+1) mod 32 in display; 0 in prefetch.
- Video slots, active windows only:
  - slot 0: ram_addr = {row[7:3], col[4:0]} zero-extended; tag=NAME.
  - slot 1: name byte arrives on ram_rdata. ram_addr = PAT_BASE + {ram_rdata[6:0], row[2:0]}; tag=PAT. Bit 7 of the name is ignored.
  - slot 2: next_bits <= ram_rdata.
  - slot 7: shifter <= next_bits.
- Shifter:
  - Shifts left by one each cycle that display_on=1 and slot!=7.
  - Holds during blanking.
  - pixel = shifter[7] & display_on.
  - Column n bits (n≥1) load at hpos 8n-1. The column 0 prefetch loads at hpos 8*PREFETCH_COL+7.
- CPU FSM, states IDLE and ACK:
  - IDLE → ACK when cpu_req=1 and the cycle is not a video slot 0/1 of an active window. Issue drives ram_addr=cpu_addr, ram_we=cpu_we, ram_wdata=cpu_wdata, tag=CPU.
  - ACK: cpu_ack=1. For reads, cpu_rdata <= ram_rdata, captured the cycle the tag is CPU. Unconditional → IDLE.
  - No issue happens in the ACK cycle, so maximum throughput is one access per 2 cycles.
- Blocked requests: a request arriving in slot 0 or 1 of an active window waits. Worst case it is issued at slot 2, so ack comes at most 3 cycles after request.
- Video always has priority. A CPU issue never coincides with a video issue.
- ram_we=1 only in a CPU write issue cycle; 0 otherwise.
- Read data is routed by the registered tag. A CPU read issued at slot 7 returns at slot 0 without disturbing video.
- cpu_req dropped while in IDLE: no access. Dropped during ACK: ignored.
- Reset mid-access: the transaction is abandoned and no ack is issued.

Decomposition:
- Package vram_arb_pkg:
  - slot constants SLOT_NAME=0, SLOT_PAT=1, SLOT_LATCH=2, SLOT_LOAD=7.
  - tag enum {NONE, NAME, PAT, CPU}.
  - FSM state enum {IDLE, ACK}.
- Sub-module tile_shifter: next_bits latch, 8-bit shifter, pixel gating. Inputs: clk, reset_n, latch, load, shift_en, display_on, data.

Test Plan:
- Reset released, no CPU traffic, vpos=0, hpos=0..7 with display_on=1 → ram_addr=0x001 at slot 0; at slot 1 with ram_rdata=0x05, ram_addr=0x428; ram_we never 1.
- Name 0x05 at row 0 → pattern byte 0xA5 → at hpos 8..15, pixel sequence 1,0,1,0,0,1,0,1.
- cpu_req write addr 0x123 data 0x5A asserted at hpos slot 0, display_on=1 → issue at slot 2 with ram_we=1, ram_addr=0x123; cpu_ack at slot 3.
- CPU read of 0x200 issued at slot 7, RAM returns 0x3C → cpu_ack next cycle with cpu_rdata=0x3C; video name fetch at that slot-0 cycle unaffected.
- display_on=0, hpos outside PREFETCH_COL, cpu_req held high continuously → ack every 2nd cycle; pixel=0; at hpos 296 ram_addr = name row (vpos+1).
- reset_n=0 during ACK state → cpu_ack=0 immediately; after release FSM is IDLE; pixel=0 until the first load.
